// File: rtl/elevator_status_display.sv
// Registered seven-segment status panel: direction, floor and door message, plus arrival blink.
// Build option ELEV_STATUS_DISPLAY_BLINK_EN enables the arrival blink FSM and its tick counter.
module elevator_status_display #(
    parameter  int MAX_FLOOR     = 32,
    parameter  int TICK_DIV      = 12_500_000,
    parameter  int ARRIVE_BLINKS = 3,
    parameter  int LEAD_ZERO     = 1,
    localparam int FLOOR_W       = $clog2(MAX_FLOOR + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic [1:0]         report_dir,
    input  logic               door_open,
    output logic [6:0]         HEX7_O,
    output logic [6:0]         HEX6_O,
    output logic [6:0]         HEX5_O,
    output logic [6:0]         HEX4_O,
    output logic [6:0]         HEX3_O,
    output logic [6:0]         HEX2_O,
    output logic [6:0]         HEX1_O,
    output logic [6:0]         HEX0_O,
    output logic               arrived
);

    localparam logic [1:0] DIR_UP   = 2'b00;
    localparam logic [1:0] DIR_STOP = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_W     = 7'b0010101;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_T     = 7'b0000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    if (MAX_FLOOR < 1 || MAX_FLOOR > 99 || TICK_DIV < 2 ||
        ARRIVE_BLINKS < 1 || ARRIVE_BLINKS > 15) begin : g_param_check
        $error("elevator_status_display: parameter out of range");
    end

    function automatic logic [6:0] f_digit(input logic [3:0] d);
        case (d)
            4'd0:    f_digit = 7'b1000000;
            4'd1:    f_digit = 7'b1111001;
            4'd2:    f_digit = 7'b0100100;
            4'd3:    f_digit = 7'b0110000;
            4'd4:    f_digit = 7'b0011001;
            4'd5:    f_digit = 7'b0010010;
            4'd6:    f_digit = 7'b0000010;
            4'd7:    f_digit = 7'b1111000;
            4'd8:    f_digit = 7'b0000000;
            4'd9:    f_digit = 7'b0010000;
            default: f_digit = SEG_BLANK;
        endcase
    endfunction

    // Stage 1: input capture; the reserved direction code 11 is folded into STOP here.
    logic [FLOOR_W-1:0] r_floor;
    logic [1:0]         r_dir;
    logic [1:0]         r_dir_d;
    logic               r_door;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_floor <= '0;
            r_dir   <= DIR_STOP;
            r_dir_d <= DIR_STOP;
            r_door  <= 1'b0;
        end else begin
            r_floor <= current_floor;
            r_dir   <= (report_dir == 2'b11) ? DIR_STOP : report_dir;
            r_dir_d <= r_dir;
            r_door  <= door_open;
        end
    end

    logic w_moving;
    logic w_arrive;

    assign w_moving = (r_dir != DIR_STOP);
    assign w_arrive = (r_dir_d != DIR_STOP) && !w_moving;

    logic [6:0] w_floor7;
    logic [3:0] w_tens;
    logic [3:0] w_ones;
    logic       w_floor_ok;
    logic [6:0] w_floor_hex5;
    logic [6:0] w_floor_hex4;

    assign w_floor7   = 7'(r_floor);
    assign w_tens     = 4'(w_floor7 / 7'd10);
    assign w_ones     = 4'(w_floor7 % 7'd10);
    assign w_floor_ok = (w_floor7 != 7'd0) && (w_floor7 <= 7'(MAX_FLOOR));

    always_comb begin
        w_floor_hex5 = SEG_DASH;
        w_floor_hex4 = SEG_DASH;
        if (w_floor_ok) begin
            w_floor_hex5 = (w_floor7 < 7'd10 && LEAD_ZERO == 0) ? SEG_BLANK : f_digit(w_tens);
            w_floor_hex4 = f_digit(w_ones);
        end
    end

    logic [27:0] w_msg;

    always_comb begin
        w_msg = {4{SEG_BLANK}};
        if (r_dir == DIR_DOWN) begin
            w_msg = {SEG_D, SEG_O, SEG_W, SEG_N};
        end else if (r_dir == DIR_STOP) begin
            w_msg = r_door ? {SEG_O, SEG_P, SEG_E, SEG_N} : {SEG_S, SEG_T, SEG_O, SEG_P};
        end
    end

    // Stage 2: every digit except the floor pair, plus the arrival pulse.
    logic [6:0] r_hex7;
    logic [6:0] r_hex6;
    logic [6:0] r_hex5;
    logic [6:0] r_hex4;
    logic [6:0] r_hex3;
    logic [6:0] r_hex2;
    logic [6:0] r_hex1;
    logic [6:0] r_hex0;
    logic       r_arrived;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex7    <= SEG_BLANK;
            r_hex6    <= SEG_BLANK;
            r_hex3    <= SEG_BLANK;
            r_hex2    <= SEG_BLANK;
            r_hex1    <= SEG_BLANK;
            r_hex0    <= SEG_BLANK;
            r_arrived <= 1'b0;
        end else begin
            r_hex7    <= (r_dir == DIR_UP) ? SEG_U : SEG_BLANK;
            r_hex6    <= (r_dir == DIR_UP) ? SEG_P : SEG_BLANK;
            {r_hex3, r_hex2, r_hex1, r_hex0} <= w_msg;
            r_arrived <= w_arrive;
        end
    end

`ifdef ELEV_STATUS_DISPLAY_BLINK_EN
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BL_OFF = 2'd1,
        ST_BL_ON  = 2'd2
    } blink_state_t;

    blink_state_t      r_state;
    logic [3:0]        r_pairs;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    // The floor pair is owned by the blink FSM so the blank lands on the same edge as the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pairs    <= 4'd0;
            r_tick_cnt <= '0;
            r_hex5     <= SEG_BLANK;
            r_hex4     <= SEG_BLANK;
        end else begin
            if (w_arrive || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
            r_hex5 <= w_floor_hex5;
            r_hex4 <= w_floor_hex4;
            if (w_moving) begin
                r_state <= ST_IDLE;
            end else if (w_arrive) begin
                r_state <= ST_BL_OFF;
                r_pairs <= 4'(ARRIVE_BLINKS);
                r_hex5  <= SEG_BLANK;
                r_hex4  <= SEG_BLANK;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_BL_OFF: begin
                        if (w_tick) begin
                            r_state <= ST_BL_ON;
                        end else begin
                            r_hex5 <= SEG_BLANK;
                            r_hex4 <= SEG_BLANK;
                        end
                    end
                    ST_BL_ON: begin
                        if (w_tick) begin
                            if (r_pairs > 4'd1) begin
                                r_state <= ST_BL_OFF;
                                r_pairs <= r_pairs - 4'd1;
                                r_hex5  <= SEG_BLANK;
                                r_hex4  <= SEG_BLANK;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex5 <= SEG_BLANK;
            r_hex4 <= SEG_BLANK;
        end else begin
            r_hex5 <= w_floor_hex5;
            r_hex4 <= w_floor_hex4;
        end
    end
`endif

    assign HEX7_O  = r_hex7;
    assign HEX6_O  = r_hex6;
    assign HEX5_O  = r_hex5;
    assign HEX4_O  = r_hex4;
    assign HEX3_O  = r_hex3;
    assign HEX2_O  = r_hex2;
    assign HEX1_O  = r_hex1;
    assign HEX0_O  = r_hex0;
    assign arrived = r_arrived;

endmodule

// File: tb/tb_elevator_status_display.sv
// Bench for elevator_status_display: directed scenarios plus random traffic against a behavioural model.
module tb_elevator_status_display;
    localparam int MAXF = 32;
    localparam int TD   = 4;
    localparam int AB   = 2;
    localparam int FW   = 6;
`ifdef ELEV_STATUS_DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] DIG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                         7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [13:0] MSG_UP    = {7'b1000001, 7'b0001100};
    localparam logic [27:0] MSG_OPEN  = {7'b1000000, 7'b0001100, 7'b0000110, 7'b0101011};
    localparam logic [27:0] MSG_DOWN  = {7'b0100001, 7'b1000000, 7'b0010101, 7'b0101011};
    localparam logic [27:0] MSG_STOP  = {7'b0010010, 7'b0000111, 7'b1000000, 7'b0001100};
    localparam logic [27:0] MSG_BLANK = {4{7'b1111111}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [FW-1:0] floor_i = '0;
    logic [1:0]    dir_i = 2'b01;
    logic          door_i = 1'b0;
    logic [6:0]    h7, h6, h5, h4, h3, h2, h1, h0;
    logic [6:0]    z7, z6, z5, z4, z3, z2, z1, z0;
    logic          arr, arr_z;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    elevator_status_display #(.MAX_FLOOR(MAXF), .TICK_DIV(TD), .ARRIVE_BLINKS(AB), .LEAD_ZERO(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .current_floor(floor_i), .report_dir(dir_i), .door_open(door_i),
        .HEX7_O(h7), .HEX6_O(h6), .HEX5_O(h5), .HEX4_O(h4),
        .HEX3_O(h3), .HEX2_O(h2), .HEX1_O(h1), .HEX0_O(h0), .arrived(arr));

    elevator_status_display #(.MAX_FLOOR(MAXF), .TICK_DIV(TD), .ARRIVE_BLINKS(AB), .LEAD_ZERO(0)) u_dut_lz0 (
        .clk(clk), .rst_n(rst_n), .current_floor(floor_i), .report_dir(dir_i), .door_open(door_i),
        .HEX7_O(z7), .HEX6_O(z6), .HEX5_O(z5), .HEX4_O(z4),
        .HEX3_O(z3), .HEX2_O(z2), .HEX1_O(z1), .HEX0_O(z0), .arrived(arr_z));

    // Reference model state: last sampled inputs, and blink age counted in displayed cycles.
    int          m_floor;
    logic [1:0]  m_dir;
    logic        m_door;
    bit          m_prev_moving;
    bit          m_blink_on;
    int          m_blink_t;
    logic [13:0] exp_hi, exp_fl, exp_fl_z;
    logic [27:0] exp_lo;
    logic        exp_arr;

    function automatic bit is_moving(input logic [1:0] d);
        return (d == 2'b00) || (d == 2'b10);
    endfunction

    function automatic logic [13:0] floor_pair(input int f, input bit lz);
        logic [6:0] tens;
        if (f < 1 || f > MAXF) return {DS, DS};
        tens = (f < 10 && !lz) ? B : DIG[f / 10];
        return {tens, DIG[f % 10]};
    endfunction

    function automatic logic [27:0] low_msg(input logic [1:0] d, input logic door);
        if (d == 2'b10) return MSG_DOWN;
        if (d == 2'b00) return MSG_BLANK;
        return door ? MSG_OPEN : MSG_STOP;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 2'b01; m_door = 1'b0;
        m_prev_moving = 1'b0; m_blink_on = 1'b0; m_blink_t = 0;
        exp_hi = {B, B}; exp_fl = {B, B}; exp_fl_z = {B, B}; exp_lo = MSG_BLANK; exp_arr = 1'b0;
    endtask

    task automatic model_update();
        bit moving_now;
        bit arrive;
        bit blank;
        moving_now = is_moving(m_dir);
        arrive     = m_prev_moving && !moving_now;
        if (moving_now) begin
            m_blink_on = 1'b0;
        end else if (arrive) begin
            m_blink_on = 1'b1;
            m_blink_t  = 0;
        end else if (m_blink_on) begin
            m_blink_t = m_blink_t + 1;
            if (m_blink_t >= 2 * AB * TD) m_blink_on = 1'b0;
        end
        blank    = BLINK && m_blink_on && (((m_blink_t / TD) % 2) == 0);
        exp_hi   = (m_dir == 2'b00) ? MSG_UP : {B, B};
        exp_lo   = low_msg(m_dir, m_door);
        exp_fl   = blank ? {B, B} : floor_pair(m_floor, 1'b1);
        exp_fl_z = blank ? {B, B} : floor_pair(m_floor, 1'b0);
        exp_arr  = arrive;
        m_prev_moving = moving_now;
        m_floor = int'(floor_i);
        m_dir   = dir_i;
        m_door  = door_i;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; floor_i = 6'd5; dir_i = 2'b01; door_i = 1'b0;
        model_reset();
        repeat (2) step();
        n_total++;
        if ({h7, h6, h5, h4, h3, h2, h1, h0, arr} !== {56'hFF_FFFF_FFFF_FFFF, 1'b0}) begin
            n_bad++; $display("FAIL reset_state: got %h want all ones, arrived 0", {h7, h6, h5, h4, h3, h2, h1, h0, arr});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            n_total++;
            if (arr !== 1'b0) begin
                n_bad++; $display("FAIL reset_release_arrived: cycle %0d got %b want 0", k, arr);
            end
        end
        n_total++;
        if ({h5, h4} !== {7'b1000000, 7'b0010010}) begin
            n_bad++; $display("FAIL reset_floor5: got %b_%b want 1000000_0010010", h5, h4);
        end
        n_total++;
        if ({h3, h2, h1, h0} !== MSG_STOP) begin
            n_bad++; $display("FAIL reset_stop_msg: got %h want %h", {h3, h2, h1, h0}, MSG_STOP);
        end
    endtask

    task automatic test_floor_range();
        int          fl [6] = '{7, 33, 32, 0, 10, 1};
        logic [13:0] e1 [6];
        logic [13:0] e0 [6];
        e1 = '{{DIG[0], DIG[7]}, {DS, DS}, {DIG[3], DIG[2]}, {DS, DS}, {DIG[1], DIG[0]}, {DIG[0], DIG[1]}};
        e0 = '{{B, DIG[7]},      {DS, DS}, {DIG[3], DIG[2]}, {DS, DS}, {DIG[1], DIG[0]}, {B, DIG[1]}};
        dir_i = 2'b00; door_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            floor_i = 6'(fl[i]);
            repeat (2) step();
            n_total++;
            if ({h5, h4} !== e1[i]) begin
                n_bad++; $display("FAIL floor_lz1 f=%0d: got %b want %b", fl[i], {h5, h4}, e1[i]);
            end
            n_total++;
            if ({z5, z4} !== e0[i]) begin
                n_bad++; $display("FAIL floor_lz0 f=%0d: got %b want %b", fl[i], {z5, z4}, e0[i]);
            end
            n_total++;
            if ({h7, h6, h3, h2, h1, h0} !== {MSG_UP, MSG_BLANK}) begin
                n_bad++; $display("FAIL up_msg f=%0d: got %h want %h", fl[i], {h7, h6, h3, h2, h1, h0}, {MSG_UP, MSG_BLANK});
            end
        end
    endtask

    task automatic test_blink();
        int          n_arr = 0;
        int          kk;
        bit          bl;
        logic [13:0] want;
        dir_i = 2'b00; floor_i = 6'd4; door_i = 1'b0;
        repeat (3) step();
        dir_i = 2'b01;
        for (int k = 0; k < 22; k++) begin
            step();
            if (arr === 1'b1) n_arr++;
            kk   = k - 1;
            bl   = BLINK && kk >= 0 && kk < 4 * TD && ((kk / TD) % 2) == 0;
            want = bl ? {B, B} : {DIG[0], DIG[4]};
            n_total++;
            if ({h5, h4} !== want) begin
                n_bad++; $display("FAIL blink_floor cycle %0d: got %b want %b", k, {h5, h4}, want);
            end
            if (k == 1) begin
                n_total++;
                if (arr !== 1'b1) begin
                    n_bad++; $display("FAIL blink_arrived_timing: got %b want 1", arr);
                end
            end
        end
        n_total++;
        if (n_arr != 1) begin
            n_bad++; $display("FAIL blink_arrived_count: got %0d want 1", n_arr);
        end
    endtask

    task automatic test_cancel();
        dir_i = 2'b00; floor_i = 6'd9; door_i = 1'b0;
        repeat (3) step();
        dir_i = 2'b01;
        repeat (6) step();
        dir_i = 2'b10;
        for (int k = 0; k < 12; k++) begin
            step();
            n_total++;
            if ({h5, h4} !== {DIG[0], DIG[9]}) begin
                n_bad++; $display("FAIL cancel_floor cycle %0d: got %b want %b", k, {h5, h4}, {DIG[0], DIG[9]});
            end
            n_total++;
            if (arr !== 1'b0) begin
                n_bad++; $display("FAIL cancel_arrived cycle %0d: got %b want 0", k, arr);
            end
            if (k >= 1) begin
                n_total++;
                if ({h3, h2, h1, h0} !== MSG_DOWN) begin
                    n_bad++; $display("FAIL cancel_down_msg cycle %0d: got %h want %h", k, {h3, h2, h1, h0}, MSG_DOWN);
                end
            end
        end
    endtask

    task automatic test_door();
        logic [1:0]  dt [6] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b11};
        logic        ot [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [27:0] et [6] = '{MSG_OPEN, MSG_DOWN, MSG_BLANK, MSG_OPEN, MSG_STOP, MSG_STOP};
        floor_i = 6'd3;
        for (int i = 0; i < 6; i++) begin
            dir_i = dt[i]; door_i = ot[i];
            repeat (2) step();
            n_total++;
            if ({h3, h2, h1, h0} !== et[i]) begin
                n_bad++; $display("FAIL door_msg dir=%b door=%b: got %h want %h", dt[i], ot[i], {h3, h2, h1, h0}, et[i]);
            end
            n_total++;
            if ({h7, h6} !== ((dt[i] == 2'b00) ? MSG_UP : {B, B})) begin
                n_bad++; $display("FAIL door_hi dir=%b: got %b", dt[i], {h7, h6});
            end
        end
    endtask

    task automatic test_reset_mid_blink();
        dir_i = 2'b00; floor_i = 6'd12; door_i = 1'b0;
        repeat (3) step();
        dir_i = 2'b01;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({h7, h6, h5, h4, h3, h2, h1, h0, z5, z4, arr, arr_z} !== {70'h3F_FFFF_FFFF_FFFF_FFFF, 2'b00}) begin
            n_bad++; $display("FAIL async_reset: got %h want all ones, arrived 0", {h7, h6, h5, h4, h3, h2, h1, h0, z5, z4, arr, arr_z});
        end
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_total++;
            if (arr !== 1'b0) begin
                n_bad++; $display("FAIL post_reset_arrived cycle %0d: got %b want 0", k, arr);
            end
            if (k >= 1) begin
                n_total++;
                if ({h5, h4, h3, h2, h1, h0} !== {DIG[1], DIG[2], MSG_STOP}) begin
                    n_bad++; $display("FAIL post_reset_display cycle %0d: got %h want %h", k, {h5, h4, h3, h2, h1, h0}, {DIG[1], DIG[2], MSG_STOP});
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 60; s++) begin
            floor_i = 6'($urandom_range(0, 40));
            dir_i   = 2'($urandom_range(0, 3));
            door_i  = 1'($urandom_range(0, 1));
            hold    = $urandom_range(1, 20);
            for (int h = 0; h < hold; h++) begin
                step();
                n_total++;
                if ({h7, h6} !== exp_hi || {z7, z6} !== exp_hi) begin
                    n_bad++; $display("FAIL rand_hi seg %0d: got %b/%b want %b", s, {h7, h6}, {z7, z6}, exp_hi);
                end
                n_total++;
                if ({h3, h2, h1, h0} !== exp_lo || {z3, z2, z1, z0} !== exp_lo) begin
                    n_bad++; $display("FAIL rand_lo seg %0d: got %h/%h want %h", s, {h3, h2, h1, h0}, {z3, z2, z1, z0}, exp_lo);
                end
                n_total++;
                if ({h5, h4} !== exp_fl) begin
                    n_bad++; $display("FAIL rand_floor_lz1 seg %0d: got %b want %b", s, {h5, h4}, exp_fl);
                end
                n_total++;
                if ({z5, z4} !== exp_fl_z) begin
                    n_bad++; $display("FAIL rand_floor_lz0 seg %0d: got %b want %b", s, {z5, z4}, exp_fl_z);
                end
                n_total++;
                if (arr !== exp_arr || arr_z !== exp_arr) begin
                    n_bad++; $display("FAIL rand_arrived seg %0d: got %b/%b want %b", s, arr, arr_z, exp_arr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_floor_range();
        test_blink();
        test_cancel();
        test_door();
        test_reset_mid_blink();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
